// File: rtl/tpu_pkg.sv
// -----------------------------------------------------------------------------
// tpu_pkg
// Shared definitions for the systolic array drain path:
//   - default array geometry (columns, accumulator and result widths, FIFO depth)
//   - collector_state_t : state encoding of the output collector FSM
//   - sat_narrow        : signed clamp of a value to an out_w-bit range
// No ports; imported by the collector and its sub-modules.
// -----------------------------------------------------------------------------
package tpu_pkg;

    localparam int TPU_N        = 4;
    localparam int TPU_ACC_W    = 32;
    localparam int TPU_OUT_W    = 16;
    localparam int TPU_DEPTH    = 8;
    localparam int TPU_MAX_ROWS = 255;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } collector_state_t;

    // Clamps a sign-extended value into [-2^(out_w-1), 2^(out_w-1)-1] when
    // saturate is set; otherwise returns it unchanged so the caller's width
    // cast performs a two's-complement wrap. The caller keeps the low out_w bits.
    function automatic logic [63:0] sat_narrow(input logic signed [63:0] value,
                                               input int unsigned        out_w,
                                               input bit                 saturate);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (out_w - 1));
        if (saturate && (value > max_v)) begin
            return max_v;
        end else if (saturate && (value < min_v)) begin
            return min_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/collector_fifo.sv
// -----------------------------------------------------------------------------
// collector_fifo
// Synchronous single-clock FIFO holding aligned result rows.
// First-word latency 1: a row written on edge t is visible on rd_data after t.
// Caller guarantees wr_en only when !full or rd_en, and rd_en only when !empty.
// Ports:
//   clock, reset (sync, active-low), clear (sync flush)
//   wr_en, wr_data      : push side
//   rd_en, rd_data      : pop side (rd_data is the head row, combinational)
//   full, empty, count  : occupancy
// -----------------------------------------------------------------------------
module collector_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // NOTE: row storage has no reset; only pointers and count are cleared, and
    //       a slot is never read before it has been written.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    //       pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/systolic_output_collector.sv
// -----------------------------------------------------------------------------
// systolic_output_collector
// Drain-side partner of the array feeder: deskews the diagonally skewed column
// results leaving the array bottom into aligned rows, narrows each column,
// buffers rows in a FIFO (the array cannot stall) and offers them to the
// result writer over valid/ready.
// Build option: define COLLECT_SAT_EN to saturate ACC_W -> OUT_W; otherwise
// each column is truncated (two's-complement wrap).
// Ports:
//   clock, reset (sync, active-low)
//   start, num_rows         : job launch (accepted in IDLE only)
//   col_valid, col_data     : per-column results, column c lags column 0 by c
//   res_valid, res_ready    : aligned-row handshake
//   res_data, res_last      : aligned row and final-row marker
//   busy, done              : job status, done is a one-cycle pulse
//   overflow, err_align     : sticky job errors
// -----------------------------------------------------------------------------
module systolic_output_collector
    import tpu_pkg::*;
#(
    parameter  int N        = TPU_N,
    parameter  int ACC_W    = TPU_ACC_W,
    parameter  int OUT_W    = TPU_OUT_W,
    parameter  int DEPTH    = TPU_DEPTH,
    parameter  int MAX_ROWS = TPU_MAX_ROWS,
    localparam int NR_W     = $clog2(MAX_ROWS + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [NR_W-1:0]    num_rows,
    input  logic [N-1:0]       col_valid,
    input  logic [N*ACC_W-1:0] col_data,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [N*OUT_W-1:0] res_data,
    output logic               res_last,
    output logic               busy,
    output logic               done,
    output logic               overflow,
    output logic               err_align
);

    localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef COLLECT_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    collector_state_t state, state_next;

    logic               capture;     // column samples are accepted only while collecting
    logic               clear;       // job launch: flush deskew, counters, stickies
    logic [N-1:0]       row_valid;   // aligned valids, one per column
    logic [N*OUT_W-1:0] row_narrow;  // aligned row after narrowing
    logic               row_seen;    // complete row arrived (counted even if dropped)
    logic               row_mixed;   // valids disagree after deskew
    logic               pop;
    logic               fifo_wr;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [N*OUT_W-1:0] fifo_rd_data;
    logic [NR_W-1:0]    rows_in;
    logic [NR_W-1:0]    num_rows_q;

    // Deskew: column c gets N-1-c delay stages so every column reaches the
    // common align register on the same edge.
    for (genvar c = 0; c < N; c++) begin : g_col
        localparam int STAGES = N - 1 - c;
        logic [ACC_W-1:0] tap_data;
        logic             tap_valid;
        logic [ACC_W-1:0] al_data;
        logic             al_valid;

        if (STAGES == 0) begin : g_direct
            assign tap_data  = col_data[c*ACC_W +: ACC_W];
            assign tap_valid = col_valid[c] & capture;
        end else begin : g_shift
            logic [ACC_W-1:0] sr_data [STAGES];
            logic [STAGES-1:0] sr_valid;

            always_ff @(posedge clock) begin
                if (!reset || clear) begin
                    sr_valid <= '0;
                    for (int i = 0; i < STAGES; i++) sr_data[i] <= '0;
                end else begin
                    sr_valid[0] <= col_valid[c] & capture;
                    sr_data[0]  <= col_data[c*ACC_W +: ACC_W];
                    for (int i = 1; i < STAGES; i++) begin
                        sr_valid[i] <= sr_valid[i-1];
                        sr_data[i]  <= sr_data[i-1];
                    end
                end
            end

            assign tap_data  = sr_data[STAGES-1];
            assign tap_valid = sr_valid[STAGES-1];
        end

        always_ff @(posedge clock) begin
            if (!reset || clear) begin
                al_valid <= 1'b0;
                al_data  <= '0;
            end else begin
                al_valid <= tap_valid;
                al_data  <= tap_data;
            end
        end

        assign row_valid[c] = al_valid;
        assign row_narrow[c*OUT_W +: OUT_W] =
            OUT_W'(sat_narrow(64'($signed(al_data)), OUT_W, SAT_EN));
    end

    assign row_seen  = capture && (&row_valid);
    assign row_mixed = capture && (|row_valid) && !(&row_valid);
    assign res_valid = !fifo_empty;
    assign pop       = res_valid && res_ready;
    // A full FIFO still accepts the row if the head leaves on the same edge.
    assign fifo_wr   = row_seen && (!fifo_full || pop);
    assign res_data  = res_valid ? fifo_rd_data : '0;

    collector_fifo #(
        .WIDTH (N * OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .clear   (clear),
        .wr_en   (fifo_wr),
        .wr_data (row_narrow),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // State register
    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    // NOTE: state_next gets a default before the case so no path leaves it
    //       unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = (num_rows == '0) ? DONE : COLLECT;
            COLLECT: if (row_seen && (rows_in == num_rows_q - 1'b1)) state_next = DRAIN;
            DRAIN:   if ((pop && res_last) || fifo_empty) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy     = (state != IDLE);
        done     = (state == DONE);
        capture  = (state == COLLECT);
        clear    = (state == IDLE) && start;
        res_last = (state == DRAIN) && (fifo_count == CNT_W'(1));
    end

    // Row counter, job length and sticky errors
    always_ff @(posedge clock) begin
        if (!reset) begin
            rows_in    <= '0;
            num_rows_q <= '0;
            overflow   <= 1'b0;
            err_align  <= 1'b0;
        end else if (clear) begin
            rows_in    <= '0;
            num_rows_q <= num_rows;
            overflow   <= 1'b0;
            err_align  <= 1'b0;
        end else begin
            if (row_seen)                          rows_in   <= rows_in + 1'b1;
            if (row_seen && fifo_full && !pop)     overflow  <= 1'b1;
            if (row_mixed)                         err_align <= 1'b1;
        end
    end

endmodule

// File: tb/tb_systolic_output_collector.sv
// -----------------------------------------------------------------------------
// tb_systolic_output_collector
// Self-checking bench for systolic_output_collector. Each job is described as a
// list of rows placed on a skewed timeline; the reference model reassembles
// rows by diagonal (slot s, column c taken from cycle s+c), applies the job
// rules (count, drop on full FIFO while the writer is stalled, misalignment)
// and produces the expected row queue and sticky flags.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_systolic_output_collector;

    localparam int N        = 4;
    localparam int ACC_W    = 32;
    localparam int OUT_W    = 16;
    localparam int DEPTH    = 8;
    localparam int MAX_ROWS = 255;
    localparam int NR_W     = $clog2(MAX_ROWS + 1);
    localparam int MAXC     = 192;
    localparam int TIMEOUT  = 3000;

`ifdef COLLECT_SAT_EN
    localparam logic [OUT_W-1:0] NARROW_A = 16'h7FFF;
    localparam logic [OUT_W-1:0] NARROW_B = 16'h8000;
`else
    localparam logic [OUT_W-1:0] NARROW_A = 16'h2345;
    localparam logic [OUT_W-1:0] NARROW_B = 16'h0000;
`endif

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic [NR_W-1:0]    num_rows = '0;
    logic [N-1:0]       col_valid = '0;
    logic [N*ACC_W-1:0] col_data = '0;
    logic               res_valid;
    logic               res_ready = 1'b0;
    logic [N*OUT_W-1:0] res_data;
    logic               res_last;
    logic               busy;
    logic               done;
    logic               overflow;
    logic               err_align;

    int checks = 0;
    int errors = 0;

    logic [N-1:0]       stim_v [MAXC];
    logic [ACC_W-1:0]   stim_d [MAXC][N];

    always #5 clock = ~clock;

    systolic_output_collector dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .num_rows  (num_rows),
        .col_valid (col_valid),
        .col_data  (col_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_last  (res_last),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .err_align (err_align)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [OUT_W-1:0] model_narrow(input logic [ACC_W-1:0] raw);
        longint      v;
        logic [63:0] bits;
        v = longint'($signed(raw));
`ifdef COLLECT_SAT_EN
        if (v > (longint'(1) << (OUT_W - 1)) - 1)   v = (longint'(1) << (OUT_W - 1)) - 1;
        else if (v < -(longint'(1) << (OUT_W - 1))) v = -(longint'(1) << (OUT_W - 1));
`endif
        bits = v;
        return bits[OUT_W-1:0];
    endfunction

    // mode 0: random, 1: sequential {1,2,3,4},{5,..}, 2: narrowing corner values
    function automatic logic [ACC_W-1:0] gen_data(input int mode, input int r, input int c);
        if (mode == 1) return ACC_W'(r * N + c + 1);
        if (mode == 2) begin
            case (c)
                0:       return 32'h0001_2345;
                1:       return 32'hFFFF_0000;
                2:       return 32'h0000_7FFF;
                default: return 32'hFFFF_8000;
            endcase
        end
        if ($urandom_range(0, 2) == 0) return $urandom();
        return ACC_W'($urandom_range(0, 2000)) - ACC_W'(1000);
    endfunction

    task automatic run_job(input string name, input int nr, input int nsend, input int mode,
                           input int mis_row, input bit hold0);
        logic [N*OUT_W-1:0] exp_q[$];
        logic [N*OUT_W-1:0] exp_row;
        logic [N*OUT_W-1:0] prev_data;
        logic               prev_last;
        bit                 prev_hold;
        bit                 exp_ovf;
        bit                 exp_err;
        bit                 finished;
        int                 slot, last_slot, gap, stim_len, counted, exp_rows;
        int                 cyc, done_cnt, done_cyc, last_xfer, nxfer;

        // Build the skewed input timeline
        for (int i = 0; i < MAXC; i++) begin
            stim_v[i] = '0;
            for (int c = 0; c < N; c++) stim_d[i][c] = '0;
        end
        slot = 0;
        last_slot = 0;
        for (int r = 0; r < nsend; r++) begin
            for (int c = 0; c < N; c++) begin
                int t;
                t = slot + c + ((r == mis_row && c == 2) ? 1 : 0);
                stim_v[t][c] = 1'b1;
                stim_d[t][c] = gen_data(mode, r, c);
            end
            last_slot = slot;
            gap = (mode == 1) ? 1 : $urandom_range(1, 3);
            if (r == mis_row && gap < 2) gap = 2;
            slot += gap;
        end
        stim_len = (nsend > 0) ? last_slot + N + 4 : 0;

        // Reference model: regroup by diagonal and apply job rules
        exp_q.delete();
        exp_ovf = 1'b0;
        exp_err = 1'b0;
        counted = 0;
        for (int s = 0; s < MAXC && counted < nr; s++) begin
            logic [N-1:0]       v;
            logic [N*OUT_W-1:0] row;
            for (int c = 0; c < N; c++) begin
                v[c] = (s + c < MAXC) ? stim_v[s+c][c] : 1'b0;
                row[c*OUT_W +: OUT_W] = (s + c < MAXC) ? model_narrow(stim_d[s+c][c]) : '0;
            end
            if (&v) begin
                counted++;
                if (hold0 && exp_q.size() >= DEPTH) exp_ovf = 1'b1;
                else                                exp_q.push_back(row);
            end else if (|v) begin
                exp_err = 1'b1;
            end
        end
        exp_rows = exp_q.size();

        @(negedge clock);
        start    = 1'b1;
        num_rows = NR_W'(nr);
        @(negedge clock);
        start    = 1'b0;
        check($sformatf("%s_busy_start", name), busy, 1);

        cyc = 0; done_cnt = 0; done_cyc = -1; last_xfer = -1; nxfer = 0;
        prev_hold = 1'b0; prev_data = '0; prev_last = 1'b0; finished = 1'b0;
        while (!finished) begin
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (prev_hold) begin
                check($sformatf("%s_hold_valid", name), res_valid, 1);
                check($sformatf("%s_hold_data", name), res_data, prev_data);
                check($sformatf("%s_hold_last", name), res_last, prev_last);
            end

            if (hold0 && cyc < stim_len + 2)  res_ready = 1'b0;
            else if (!hold0 && cyc < stim_len) res_ready = 1'b1;
            else                               res_ready = 1'($urandom_range(0, 1));

            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("%s_unexpected_row", name), res_valid, 0);
                end else begin
                    exp_row = exp_q.pop_front();
                    check($sformatf("%s_row%0d_data", name, nxfer), res_data, exp_row);
                    check($sformatf("%s_row%0d_last", name, nxfer), res_last, exp_q.size() == 0);
                    if (mode == 2 && nxfer == 0)
                        check($sformatf("%s_const_row", name), res_data,
                              {16'h8000, 16'h7FFF, NARROW_B, NARROW_A});
                end
                nxfer++;
                last_xfer = cyc;
            end
            prev_hold = res_valid && !res_ready;
            prev_data = res_data;
            prev_last = res_last;

            // A start while busy must be ignored
            start = (nr > 0 && cyc == 2);
            if (start) num_rows = NR_W'($urandom_range(1, MAX_ROWS));

            col_valid = '0;
            col_data  = '0;
            if (cyc < stim_len) begin
                col_valid = stim_v[cyc];
                for (int c = 0; c < N; c++) col_data[c*ACC_W +: ACC_W] = stim_d[cyc][c];
            end

            if (done_cyc >= 0 && cyc > done_cyc && cyc >= stim_len) begin
                finished = 1'b1;
            end else if (cyc >= TIMEOUT) begin
                check($sformatf("%s_timeout_busy", name), busy, 0);
                finished = 1'b1;
            end
            @(negedge clock);
            cyc++;
        end
        col_valid = '0;
        col_data  = '0;
        start     = 1'b0;

        check($sformatf("%s_rows_out", name), nxfer, exp_rows);
        check($sformatf("%s_done_pulses", name), done_cnt, 1);
        check($sformatf("%s_done_cycle", name), done_cyc, (exp_rows > 0) ? last_xfer + 1 : 0);
        check($sformatf("%s_busy_end", name), busy, 0);
        check($sformatf("%s_valid_end", name), res_valid, 0);
        check($sformatf("%s_overflow", name), overflow, exp_ovf);
        check($sformatf("%s_err_align", name), err_align, exp_err);
    endtask

    initial begin
        int nr;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_last", res_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_err_align", err_align, 0);
        reset = 1'b1;
        @(negedge clock);

        run_job("seq4",     4,  4, 1, -1, 1'b0);
        run_job("hold4",    4,  4, 0, -1, 1'b1);
        run_job("ovf10",   10, 10, 0, -1, 1'b1);
        run_job("misalign", 4,  5, 0,  0, 1'b0);
        run_job("narrow",   1,  1, 2, -1, 1'b0);

        // Reset in the middle of a job: one row buffered, err_align raised
        @(negedge clock);
        start     = 1'b1;
        num_rows  = NR_W'(4);
        res_ready = 1'b0;
        @(negedge clock);
        start = 1'b0;
        for (int t = 0; t < N + 9; t++) begin
            col_valid = '0;
            col_data  = '0;
            if (t < N) begin
                col_valid[t] = 1'b1;
                col_data[t*ACC_W +: ACC_W] = $urandom();
            end
            if (t == N + 1) col_valid[0] = 1'b1;
            @(negedge clock);
        end
        col_valid = '0;
        col_data  = '0;
        check("mid_valid_before_rst", res_valid, 1);
        check("mid_err_before_rst", err_align, 1);
        check("mid_busy_before_rst", busy, 1);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        check("mid_rst_res_valid", res_valid, 0);
        check("mid_rst_res_data", res_data, 0);
        check("mid_rst_res_last", res_last, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_err_align", err_align, 0);
        check("mid_rst_overflow", overflow, 0);

        run_job("after_rst", 4, 4, 1, -1, 1'b0);
        run_job("zero_rows", 0, 0, 0, -1, 1'b0);

        for (int j = 0; j < 6; j++) begin
            nr = $urandom_range(1, 12);
            run_job($sformatf("rand%0d", j), nr, nr + $urandom_range(0, 2), 0, -1,
                    1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
